// File: rtl/rect_fill_queue_engine.sv
// rect_fill_queue_engine: queued axis-aligned rectangle filler; Avalon slave command port,
// Avalon master pixel writer with abort and a sticky-done interrupt.
module rect_fill_queue_engine #(
    parameter int          X_W          = 9,
    parameter int          Y_W          = 8,
    parameter int          PIXEL_W      = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] FB_BASE      = 32'h0,
    parameter int          STRIDE_BYTES = 1024
) (
    input  logic                 csi_clockreset_clk,
    input  logic                 csi_clockreset_reset,
    input  logic                 avs_slave_chipselect,
    input  logic [2:0]           avs_slave_address,
    input  logic                 avs_slave_read,
    input  logic                 avs_slave_write,
    input  logic [31:0]          avs_slave_writedata,
    output logic [31:0]          avs_slave_readdata,
    input  logic                 avm_master_waitrequest,
    output logic [31:0]          avm_master_address,
    output logic                 avm_master_write,
    output logic [PIXEL_W-1:0]   avm_master_writedata,
    output logic [PIXEL_W/8-1:0] avm_master_byteenable,
    output logic                 ins_irq
);
    localparam int BPP   = PIXEL_W / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int CMD_W = 2 * X_W + 2 * Y_W + PIXEL_W;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

    logic clk, rst;
    assign clk = csi_clockreset_clk;
    assign rst = csi_clockreset_reset;

    logic [X_W-1:0]     x0_q, x1_q, xlo_q, xlo_d, xhi_q, xhi_d, cur_x_q, cur_x_d, hx0, hx1;
    logic [Y_W-1:0]     y0_q, y1_q, ylo_q, ylo_d, yhi_q, yhi_d, cur_y_q, cur_y_d, hy0, hy1;
    logic [PIXEL_W-1:0] color_q, col_q, col_d, hcol;
    logic [CMD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               irq_en_q, ovf_q, done_q, abort_pend_q, abort_pend_d, done_set;
    state_t             state_q, state_d;

    logic wr_en, push, abort, stat_wr, fifo_full, fifo_empty, push_ok, pop, accept, last_px, busy;
    logic unused_ok;

    assign unused_ok  = ^{avs_slave_writedata, avs_slave_read};
    assign wr_en      = avs_slave_chipselect & avs_slave_write;
    assign push       = wr_en && avs_slave_address == 3'd5;
    assign stat_wr    = wr_en && avs_slave_address == 3'd6;
    assign abort      = wr_en && avs_slave_address == 3'd7 && avs_slave_writedata[0];
    assign fifo_full  = count_q == CW'(FIFO_DEPTH);
    assign fifo_empty = count_q == '0;
    assign push_ok    = push && !fifo_full;
    assign pop        = state_q == LOAD && !abort;
    assign accept     = state_q == WRITE && !avm_master_waitrequest;
    assign last_px    = cur_x_q == xhi_q && cur_y_q == yhi_q;
    assign busy       = state_q != IDLE || !fifo_empty;
    assign {hx0, hy0, hx1, hy1, hcol} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok && !abort)
            mem_q[wr_ptr_q] <= {x0_q, y0_q, x1_q, y1_q, color_q};
    end

    // Abort flushes the queue outright, discarding any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_ok);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_q + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (wr_en && avs_slave_address == 3'd0) x0_q <= avs_slave_writedata[X_W-1:0];
            if (wr_en && avs_slave_address == 3'd1) y0_q <= avs_slave_writedata[Y_W-1:0];
            if (wr_en && avs_slave_address == 3'd2) x1_q <= avs_slave_writedata[X_W-1:0];
            if (wr_en && avs_slave_address == 3'd3) y1_q <= avs_slave_writedata[Y_W-1:0];
            if (wr_en && avs_slave_address == 3'd4) color_q <= avs_slave_writedata[PIXEL_W-1:0];
            if (wr_en && avs_slave_address == 3'd7) irq_en_q <= avs_slave_writedata[1];
            ovf_q  <= (ovf_q & ~(stat_wr & avs_slave_writedata[2])) | (push & fifo_full);
            done_q <= (done_q & ~(stat_wr & avs_slave_writedata[3])) | done_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            xlo_q        <= '0;
            xhi_q        <= '0;
            ylo_q        <= '0;
            yhi_q        <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            col_q        <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            xlo_q        <= xlo_d;
            xhi_q        <= xhi_d;
            ylo_q        <= ylo_d;
            yhi_q        <= yhi_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            col_q        <= col_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        xlo_d        = xlo_q;
        xhi_d        = xhi_q;
        ylo_d        = ylo_q;
        yhi_d        = yhi_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        col_d        = col_q;
        abort_pend_d = abort_pend_q;
        done_set     = 1'b0;
        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (!fifo_empty && !abort) state_d = LOAD;
            end
            LOAD: begin
                state_d      = abort ? IDLE : WRITE;
                abort_pend_d = 1'b0;
                xlo_d        = hx0 < hx1 ? hx0 : hx1;
                xhi_d        = hx0 < hx1 ? hx1 : hx0;
                ylo_d        = hy0 < hy1 ? hy0 : hy1;
                yhi_d        = hy0 < hy1 ? hy1 : hy0;
                cur_x_d      = xlo_d;
                cur_y_d      = ylo_d;
                col_d        = hcol;
            end
            WRITE: begin
                // An abort lets the presented pixel finish so the bus transfer is never torn.
                if (abort) abort_pend_d = 1'b1;
                if (accept) begin
                    if (abort || abort_pend_q) begin
                        state_d = IDLE;
                    end else if (last_px) begin
                        state_d  = fifo_empty ? IDLE : LOAD;
                        done_set = fifo_empty;
                    end else if (cur_x_q == xhi_q) begin
                        cur_x_d = xlo_q;
                        cur_y_d = cur_y_q + 1'b1;
                    end else begin
                        cur_x_d = cur_x_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign avm_master_write      = state_q == WRITE;
    assign avm_master_address    = avm_master_write
                                 ? FB_BASE + 32'(cur_y_q) * 32'(STRIDE_BYTES) + 32'(cur_x_q) * 32'(BPP)
                                 : '0;
    assign avm_master_writedata  = avm_master_write ? col_q : '0;
    assign avm_master_byteenable = '1;
    assign ins_irq               = done_q & irq_en_q;

    always_comb begin
        avs_slave_readdata = '0;
        case (avs_slave_address)
            3'd0: avs_slave_readdata = 32'(x0_q);
            3'd1: avs_slave_readdata = 32'(y0_q);
            3'd2: avs_slave_readdata = 32'(x1_q);
            3'd3: avs_slave_readdata = 32'(y1_q);
            3'd4: avs_slave_readdata = 32'(color_q);
            3'd6: avs_slave_readdata = {16'd0, 8'(count_q), 4'd0, done_q, ovf_q, fifo_full, busy};
            3'd7: avs_slave_readdata = {30'd0, irq_en_q, 1'b0};
            default: avs_slave_readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_rect_fill_queue_engine.sv
// tb_rect_fill_queue_engine: scoreboard bench; every pushed rectangle expands into
// expected (address, colour) pairs that are popped as the master accepts pixels.
module tb_rect_fill_queue_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        cs, rd, wr, waitreq;
    logic [2:0]  addr;
    logic [31:0] wdata, rdata, m_addr;
    logic        m_write, irq;
    logic [15:0] m_data;
    logic [1:0]  m_be;

    int checks = 0, errors = 0;
    int acc = 0, wr_cycles = 0, stall_cnt = 0, cyc = 0, first_wr = -1, last_wr = -1;
    logic [47:0] exp_q[$];
    logic        stall_q = 1'b0;
    logic [31:0] hold_addr;
    logic [15:0] hold_data;

    rect_fill_queue_engine #(
        .X_W(9), .Y_W(8), .PIXEL_W(16), .FIFO_DEPTH(4), .FB_BASE(32'h0), .STRIDE_BYTES(1024)
    ) dut (
        .csi_clockreset_clk    (clk),
        .csi_clockreset_reset  (rst),
        .avs_slave_chipselect  (cs),
        .avs_slave_address     (addr),
        .avs_slave_read        (rd),
        .avs_slave_write       (wr),
        .avs_slave_writedata   (wdata),
        .avs_slave_readdata    (rdata),
        .avm_master_waitrequest(waitreq),
        .avm_master_address    (m_addr),
        .avm_master_write      (m_write),
        .avm_master_writedata  (m_data),
        .avm_master_byteenable (m_be),
        .ins_irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Inputs are stable between the falling edge and the next rising edge, so the
    // acceptance decision seen here is the one the DUT acts on.
    always @(negedge clk) begin
        logic [47:0] e;
        cyc++;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_wr", 32'(m_write), 32'd1);
                check("hold_addr", m_addr, hold_addr);
                check("hold_data", 32'(m_data), 32'(hold_data));
            end
            stall_q   = m_write && waitreq;
            hold_addr = m_addr;
            hold_data = m_data;
            if (m_write) begin
                wr_cycles++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (waitreq) stall_cnt++;
            end
            if (m_write && !waitreq) begin
                acc++;
                e = exp_q.size() > 0 ? exp_q.pop_front() : 48'hFFFF_FFFF_FFFF;
                check("px_addr", m_addr, e[47:16]);
                check("px_data", 32'(m_data), 32'(e[15:0]));
                check("px_be", 32'(m_be), 32'h3);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick(1);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        d = rdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [15:0] col, input bit keep);
        int xl, xh, yl, yh;
        reg_wr(3'd0, 32'(x0));
        reg_wr(3'd1, 32'(y0));
        reg_wr(3'd2, 32'(x1));
        reg_wr(3'd3, 32'(y1));
        reg_wr(3'd4, 32'(col));
        xl = x0 < x1 ? x0 : x1;  xh = x0 < x1 ? x1 : x0;
        yl = y0 < y1 ? y0 : y1;  yh = y0 < y1 ? y1 : y0;
        if (keep)
            for (int y = yl; y <= yh; y++)
                for (int x = xl; x <= xh; x++)
                    exp_q.push_back({32'(y * 1024 + x * 2), col});
        reg_wr(3'd5, 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        logic [31:0] s;
        int n = 0;
        reg_rd(3'd6, s);
        while (s[0] && n < limit) begin
            tick(1);
            n++;
            reg_rd(3'd6, s);
        end
        check("idle_in_time", 32'(s[0]), 32'd0);
    endtask

    initial begin
        logic [31:0] s;
        int base, wbase, sbase;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; waitreq = 1'b0;
        tick(3);
        rst = 1'b0;
        check("rst_write", 32'(m_write), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_addr", m_addr, 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        reg_rd(3'd6, s); check("rst_status", s, 32'd0);
        reg_rd(3'd7, s); check("rst_control", s, 32'd0);

        // single pixel, also the push-to-write latency
        base = acc;
        push_rect(5, 3, 5, 3, 16'hF800, 1'b1);
        check("lat_c0", 32'(m_write), 32'd0);
        tick(1); check("lat_c1", 32'(m_write), 32'd0);
        tick(1); check("lat_c2", 32'(m_write), 32'd1);
        check("lat_addr", m_addr, 32'h0C0A);
        wait_idle(50);
        check("one_acc", 32'(acc - base), 32'd1);
        check("one_scb", 32'(exp_q.size()), 32'd0);
        reg_rd(3'd6, s);
        check("one_done", 32'(s[3]), 32'd1);
        check("one_busy", 32'(s[0]), 32'd0);

        // swapped corners, streaming without stalls
        base = acc; wbase = wr_cycles; first_wr = -1;
        push_rect(12, 2, 10, 1, 16'h07E0, 1'b1);
        wait_idle(50);
        check("rect_acc", 32'(acc - base), 32'd6);
        check("rect_wrcyc", 32'(wr_cycles - wbase), 32'd6);
        check("rect_contig", 32'(last_wr - first_wr + 1), 32'd6);
        check("rect_scb", 32'(exp_q.size()), 32'd0);

        // same rectangle, three stall cycles on the second pixel
        base = acc; sbase = stall_cnt;
        push_rect(12, 2, 10, 1, 16'h001F, 1'b1);
        for (int n = 0; n < 30 && acc - base < 1; n++) tick(1);
        waitreq = 1'b1;
        tick(3);
        waitreq = 1'b0;
        wait_idle(50);
        check("stall_cnt", 32'(stall_cnt - sbase), 32'd3);
        check("stall_acc", 32'(acc - base), 32'd6);
        check("stall_scb", 32'(exp_q.size()), 32'd0);

        // overflow: first fill stalls after its pop, then five pushes into a depth-4 queue
        base = acc;
        waitreq = 1'b1;
        push_rect(100, 50, 101, 50, 16'hAAAA, 1'b1);
        tick(3);
        for (int i = 0; i < 5; i++) push_rect(i * 4, 60, i * 4 + 1, 60, 16'(16'h1100 + i), i < 4);
        reg_rd(3'd6, s);
        check("ovf_count", 32'(s[15:8]), 32'd4);
        check("ovf_full", 32'(s[1]), 32'd1);
        check("ovf_flag", 32'(s[2]), 32'd1);
        check("ovf_busy", 32'(s[0]), 32'd1);
        waitreq = 1'b0;
        wait_idle(200);
        check("ovf_acc", 32'(acc - base), 32'd10);
        check("ovf_scb", 32'(exp_q.size()), 32'd0);
        reg_wr(3'd6, 32'h4);
        reg_rd(3'd6, s);
        check("ovf_clr", 32'(s[2]), 32'd0);
        check("ovf_done_kept", 32'(s[3]), 32'd1);

        // abort on the third pixel of a 4x4 fill with two more queued
        reg_wr(3'd6, 32'hC);
        base = acc;
        waitreq = 1'b1;
        push_rect(0, 20, 3, 23, 16'h1234, 1'b1);
        push_rect(30, 30, 31, 30, 16'h5555, 1'b1);
        push_rect(40, 30, 41, 31, 16'h6666, 1'b1);
        waitreq = 1'b0;
        for (int n = 0; n < 30 && acc - base < 2; n++) tick(1);
        waitreq = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        reg_wr(3'd7, 32'h1);
        tick(1);
        waitreq = 1'b0;
        tick(10);
        check("abort_acc", 32'(acc - base), 32'd3);
        check("abort_scb", 32'(exp_q.size()), 32'd0);
        check("abort_wr", 32'(m_write), 32'd0);
        reg_rd(3'd6, s);
        check("abort_count", 32'(s[15:8]), 32'd0);
        check("abort_busy", 32'(s[0]), 32'd0);
        check("abort_done", 32'(s[3]), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);

        // interrupt follows done while enabled
        reg_wr(3'd7, 32'h2);
        reg_rd(3'd7, s); check("ctrl_rd", s, 32'h2);
        check("irq_pre", 32'(irq), 32'd0);
        push_rect(7, 7, 7, 7, 16'hBEEF, 1'b1);
        wait_idle(50);
        check("irq_set", 32'(irq), 32'd1);
        tick(3);
        check("irq_held", 32'(irq), 32'd1);
        reg_wr(3'd6, 32'h8);
        check("irq_clr", 32'(irq), 32'd0);

        // reset in the middle of a fill
        push_rect(0, 0, 3, 3, 16'hCAFE, 1'b1);
        tick(4);
        check("mid_wr", 32'(m_write), 32'd1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_wr", 32'(m_write), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        reg_rd(3'd6, s); check("rst_mid_status", s, 32'd0);
        reg_rd(3'd7, s); check("rst_mid_ctrl", s, 32'd0);
        reg_rd(3'd0, s); check("rst_mid_x0", s, 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        tick(3);
        check("rst_mid_quiet", 32'(m_write), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
